// File: rtl/gray_arb_pkg.sv
// rtl/gray_arb_pkg.sv - shared constants, tag type and pointer helper for gray_mem_arbiter
//
// Purpose: default widths derived from the 128x128 grayscale image, the
// read-tag record carried alongside each in-flight memory read, and the
// round-robin pointer increment used by the arbiter.
// Ports: none (package).
// Optional build macro used by the arbiter: FIXED_PRIO_REQ0_EN.

package gray_arb_pkg;

  localparam int IMG_W  = 128;
  localparam int IMG_H  = 128;
  localparam int AW_DEF = $clog2(IMG_W * IMG_H);
  localparam int DW_DEF = 8;

  // Wide enough to name any of up to 8 requesters.
  localparam int IDX_W  = 3;

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
  } tag_t;

  function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] ptr,
                                                 input int               nreq);
    if (int'(ptr) >= nreq - 1) return '0;
    return ptr + 1'b1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker with optional priority mask
//
// Purpose: selects one requester from req. Any request whose prio_mask bit is
// set wins outright (lowest index first); otherwise the first requester at or
// after ptr, wrapping modulo NREQ, is chosen.
// Ports:
//   req        in   NREQ   request vector
//   ptr        in   IDX_W  round-robin start position
//   prio_mask  in   NREQ   requesters with absolute priority
//   grant      out  NREQ   one-hot grant (zero when nothing requested)
//   idx        out  IDX_W  index of the granted requester
//   any        out  1      a grant was made

module rr_pick
  import gray_arb_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  input  logic [NREQ-1:0]  prio_mask,
  output logic [NREQ-1:0]  grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [NREQ-1:0] hi_req;
  logic [NREQ-1:0] lo_req;
  int              j;

  always_comb begin
    hi_req = req & prio_mask;
    lo_req = req & ~prio_mask;
    grant  = '0;
    idx    = '0;
    any    = 1'b0;
    j      = 0;

    // Scan downwards so the last hit written is the lowest index.
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (hi_req[i]) begin
        grant = NREQ'(1) << i;
        idx   = IDX_W'(i);
        any   = 1'b1;
      end
    end

    // Same trick for round-robin: k=0 (the pointer itself) is written last.
    if (!any) begin
      for (int k = NREQ - 1; k >= 0; k--) begin
        j = (int'(ptr) + k) % NREQ;
        if (lo_req[j]) begin
          grant = NREQ'(1) << j;
          idx   = IDX_W'(j);
          any   = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/gray_mem_arbiter.sv
// rtl/gray_mem_arbiter.sv - round-robin arbiter sharing the grayscale image read port
//
// Purpose: grants at most one read per cycle among NREQ pixel-fetch engines,
// drives the registered memory address/strobe, and routes each returned pixel
// back to the requester that issued it, in issue order.
// Build macro: FIXED_PRIO_REQ0_EN gives requester 0 absolute priority; the
// others keep round-robin and only their grants move the pointer.
// Ports:
//   clk        in   1        rising-edge clock
//   reset      in   1        synchronous, active-low reset
//   req_valid  in   NREQ     per-requester read request
//   req_addr   in   NREQ*AW  packed addresses, requester i at [i*AW +: AW]
//   req_ready  out  NREQ     one-hot accept
//   rsp_valid  out  NREQ     one-hot pulse marking rsp_data's owner
//   rsp_data   out  DW       returned pixel
//   mem_addr   out  AW       registered memory address
//   mem_req    out  1        registered read strobe
//   mem_ready  in   1        memory can accept a read this cycle
//   mem_data   in   DW       memory read data, RD_LAT cycles after mem_req
//   busy       out  1        request pending or read in flight

module gray_mem_arbiter
  import gray_arb_pkg::*;
#(
  parameter int NREQ   = 2,
  parameter int AW     = AW_DEF,
  parameter int DW     = DW_DEF,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*AW-1:0] req_addr,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [DW-1:0]     rsp_data,
  output logic [AW-1:0]     mem_addr,
  output logic              mem_req,
  input  logic              mem_ready,
  input  logic [DW-1:0]     mem_data,
  output logic              busy
);

  logic [IDX_W-1:0] ptr;
  logic [NREQ-1:0]  prio_mask;
  logic [NREQ-1:0]  pick_grant;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;
  logic             grant_en;
  logic [AW-1:0]    sel_addr;
  logic [IDX_W-1:0] mem_idx;
  logic             tag_any;
  tag_t             tag_pipe [RD_LAT];

`ifdef FIXED_PRIO_REQ0_EN
  assign prio_mask = NREQ'(1);
`else
  assign prio_mask = '0;
`endif

  rr_pick #(
    .NREQ (NREQ)
  ) u_pick (
    .req       (req_valid),
    .ptr       (ptr),
    .prio_mask (prio_mask),
    .grant     (pick_grant),
    .idx       (pick_idx),
    .any       (pick_any)
  );

  // No grant while reset is low or the memory is stalled.
  assign grant_en  = reset & mem_ready & pick_any;
  assign req_ready = grant_en ? pick_grant : '0;

  always_comb begin
    sel_addr = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_idx == IDX_W'(i)) sel_addr = req_addr[i*AW +: AW];
    end
  end

  always_comb begin
    tag_any = 1'b0;
    for (int i = 0; i < RD_LAT; i++) tag_any = tag_any | tag_pipe[i].valid;
  end

  assign busy = (|req_valid) | tag_any | mem_req;

  always_ff @(posedge clk) begin
    if (!reset) begin
      mem_addr  <= '0;
      mem_req   <= 1'b0;
      mem_idx   <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
      ptr       <= '0;
      for (int i = 0; i < RD_LAT; i++) tag_pipe[i] <= '0;
    end else begin
      mem_req <= grant_en;
      if (grant_en) begin
        mem_addr <= sel_addr;
        mem_idx  <= pick_idx;
        // Priority-lane grants leave the rotation where it was.
        if (!(|(pick_grant & prio_mask))) ptr <= next_ptr(pick_idx, NREQ);
      end

      // Stage 0 follows the registered strobe, so the last stage lines up
      // with mem_data RD_LAT cycles after the mem_req cycle.
      tag_pipe[0] <= '{valid: mem_req, idx: mem_idx};
      for (int i = 1; i < RD_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];

      if (tag_pipe[RD_LAT-1].valid) begin
        rsp_valid <= NREQ'(1) << tag_pipe[RD_LAT-1].idx;
        rsp_data  <= mem_data;
      end else begin
        rsp_valid <= '0;
      end
    end
  end

endmodule

// File: tb/tb_gray_mem_arbiter.sv
// tb/tb_gray_mem_arbiter.sv - directed self-checking bench for gray_mem_arbiter

module tb_gray_mem_arbiter;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_reset, b_reset;
  logic [1:0]  a_req_valid, a_req_ready, a_rsp_valid;
  logic [27:0] a_req_addr;
  logic [7:0]  a_rsp_data, a_mem_data;
  logic [13:0] a_mem_addr;
  logic        a_mem_req, a_mem_ready, a_busy;

  logic [1:0]  b_req_valid, b_req_ready, b_rsp_valid;
  logic [27:0] b_req_addr;
  logic [7:0]  b_rsp_data, b_mem_data;
  logic [13:0] b_mem_addr;
  logic        b_mem_req, b_mem_ready, b_busy;

  gray_mem_arbiter #(.NREQ(2), .AW(14), .DW(8), .RD_LAT(1)) dut_a (
    .clk(clk), .reset(a_reset), .req_valid(a_req_valid), .req_addr(a_req_addr),
    .req_ready(a_req_ready), .rsp_valid(a_rsp_valid), .rsp_data(a_rsp_data),
    .mem_addr(a_mem_addr), .mem_req(a_mem_req), .mem_ready(a_mem_ready),
    .mem_data(a_mem_data), .busy(a_busy)
  );

  gray_mem_arbiter #(.NREQ(2), .AW(14), .DW(8), .RD_LAT(3)) dut_b (
    .clk(clk), .reset(b_reset), .req_valid(b_req_valid), .req_addr(b_req_addr),
    .req_ready(b_req_ready), .rsp_valid(b_rsp_valid), .rsp_data(b_rsp_data),
    .mem_addr(b_mem_addr), .mem_req(b_mem_req), .mem_ready(b_mem_ready),
    .mem_data(b_mem_data), .busy(b_busy)
  );

  function automatic logic [7:0] pix(input logic [13:0] a);
    return a[7:0] ^ 8'hDB;
  endfunction

  // Image memories: latency 1 and 3 from the registered address.
  logic [7:0] a_d0;
  logic [7:0] b_d [3];
  always @(posedge clk) a_d0 <= pix(a_mem_addr);
  always @(posedge clk) begin
    b_d[0] <= pix(b_mem_addr);
    b_d[1] <= b_d[0];
    b_d[2] <= b_d[1];
  end
  assign a_mem_data = a_d0;
  assign b_mem_data = b_d[2];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Expected responses for dut_a: {owner one-hot, data}.
  logic [9:0] exp_q [$];
  logic [9:0] e;

  always @(negedge clk) begin
    if (a_rsp_valid != 2'b00) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 32'(a_rsp_valid), 32'h0);
      end else begin
        e = exp_q.pop_front();
        check("rsp_owner", 32'(a_rsp_valid), 32'(e[9:8]));
        check("rsp_data", 32'(a_rsp_data), 32'(e[7:0]));
      end
    end
  end

  function automatic logic [9:0] exp_entry(input int g, input logic [27:0] addrs);
    logic [13:0] ad;
    ad = (g == 0) ? addrs[13:0] : addrs[27:14];
    return {2'(1 << g), pix(ad)};
  endfunction

  int exp3 [12];
  logic [1:0] rdy4 [8];
  logic [1:0] rdy6 [4];
  logic       mr4  [8];
  int         cnt0, cnt1, g;

  initial begin
`ifdef FIXED_PRIO_REQ0_EN
    exp3 = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1};
    rdy4 = '{2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01};
    rdy6 = '{2'b01, 2'b01, 2'b01, 2'b01};
`else
    exp3 = '{1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0};
    rdy4 = '{2'b10, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b01};
    rdy6 = '{2'b10, 2'b01, 2'b10, 2'b01};
`endif
    mr4 = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    // 1: reset then idle
    a_reset = 1'b0; b_reset = 1'b0;
    a_req_valid = 2'b11; a_req_addr = '0; a_mem_ready = 1'b1;
    b_req_valid = 2'b00; b_req_addr = '0; b_mem_ready = 1'b1;
    @(negedge clk); #1;
    check("rdy_in_reset", 32'(a_req_ready), 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    a_reset = 1'b1; b_reset = 1'b1; a_req_valid = 2'b00;
    @(negedge clk); #1;
    check("idle_mem_req", 32'(a_mem_req), 32'h0);
    check("idle_mem_addr", 32'(a_mem_addr), 32'h0);
    check("idle_rsp_valid", 32'(a_rsp_valid), 32'h0);
    check("idle_busy", 32'(a_busy), 32'h0);
    check("idle_req_ready", 32'(a_req_ready), 32'h0);

    // 2: single read, RD_LAT=1
    a_req_valid = 2'b01; a_req_addr = {14'h0, 14'h0081};
    #1;
    check("t2_ready", 32'(a_req_ready), 32'h1);
    check("t2_busy", 32'(a_busy), 32'h1);
    exp_q.push_back({2'b01, 8'h5A});
    @(negedge clk);
    a_req_valid = 2'b00;
    #1;
    check("t2_mem_req", 32'(a_mem_req), 32'h1);
    check("t2_mem_addr", 32'(a_mem_addr), 32'h0081);
    @(negedge clk); #1;
    check("t2_mem_req_off", 32'(a_mem_req), 32'h0);
    check("t2_rsp_early", 32'(a_rsp_valid), 32'h0);
    @(negedge clk); #1;
    check("t2_rsp_valid", 32'(a_rsp_valid), 32'h1);
    check("t2_rsp_data", 32'(a_rsp_data), 32'h5A);
    @(negedge clk); #1;
    check("t2_rsp_off", 32'(a_rsp_valid), 32'h0);
    check("t2_busy_off", 32'(a_busy), 32'h0);

    // 3: contention, 6 reads each
    cnt0 = 0; cnt1 = 0;
    for (int gi = 0; gi < 12; gi++) begin
      a_req_valid = {cnt1 < 6, cnt0 < 6};
      a_req_addr  = {14'(14'h0200 + cnt1), 14'(14'h0100 + cnt0)};
      #1;
      g = exp3[gi];
      check("t3_grant", 32'(a_req_ready), 32'(1 << g));
      exp_q.push_back(exp_entry(g, a_req_addr));
      if (a_req_ready[0]) cnt0++;
      if (a_req_ready[1]) cnt1++;
      @(negedge clk);
    end
    a_req_valid = 2'b00;
    repeat (4) @(negedge clk);
    #1;
    check("t3_all_returned", 32'(exp_q.size()), 32'h0);

    // 4: memory backpressure mid-burst
    cnt0 = 0; cnt1 = 0;
    for (int k = 0; k < 8; k++) begin
      a_req_valid = 2'b11;
      a_req_addr  = {14'(14'h0400 + cnt1), 14'(14'h0300 + cnt0)};
      a_mem_ready = mr4[k];
      #1;
      check("t4_ready", 32'(a_req_ready), 32'(rdy4[k]));
      if (k > 0) check("t4_mem_req", 32'(a_mem_req), 32'(rdy4[k-1] != 2'b00));
      if (k == 4) check("t4_inflight_done", 32'(exp_q.size()), 32'h0);
      if (rdy4[k] != 2'b00) exp_q.push_back(exp_entry(rdy4[k][1] ? 1 : 0, a_req_addr));
      if (a_req_ready[0]) cnt0++;
      if (a_req_ready[1]) cnt1++;
      @(negedge clk);
    end
    a_req_valid = 2'b00; a_mem_ready = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    check("t4_all_returned", 32'(exp_q.size()), 32'h0);
    check("t4_busy_off", 32'(a_busy), 32'h0);

    // 6: both valid, then requester 1 alone
    cnt0 = 0; cnt1 = 0;
    for (int k = 0; k < 6; k++) begin
      a_req_valid = (k < 4) ? 2'b11 : 2'b10;
      a_req_addr  = {14'(14'h0600 + cnt1), 14'(14'h0500 + cnt0)};
      #1;
      if (k < 4) begin
        check("t6_grant", 32'(a_req_ready), 32'(rdy6[k]));
        exp_q.push_back(exp_entry(rdy6[k][1] ? 1 : 0, a_req_addr));
      end else begin
        check("t6_solo_grant", 32'(a_req_ready), 32'h2);
        exp_q.push_back(exp_entry(1, a_req_addr));
      end
      if (a_req_ready[0]) cnt0++;
      if (a_req_ready[1]) cnt1++;
      @(negedge clk);
    end
    a_req_valid = 2'b00;
    repeat (4) @(negedge clk);
    #1;
    check("t6_all_returned", 32'(exp_q.size()), 32'h0);

    // 5: reset mid-burst on the RD_LAT=3 instance
    for (int k = 0; k < 3; k++) begin
      b_req_valid = 2'b01;
      b_req_addr  = {14'h0, 14'(14'h0010 + k)};
      #1;
      check("t5_solo_grant", 32'(b_req_ready), 32'h1);
      @(negedge clk);
    end
    b_reset = 1'b0;
    b_req_valid = 2'b11;
    b_req_addr  = {14'h0030, 14'h0020};
    #1;
    check("t5_rdy_in_reset", 32'(b_req_ready), 32'h0);
    check("t5_mem_req_pre", 32'(b_mem_req), 32'h1);
    @(negedge clk);
    b_reset = 1'b1;
    #1;
    check("t5_mem_req_cleared", 32'(b_mem_req), 32'h0);
    check("t5_rsp_cleared", 32'(b_rsp_valid), 32'h0);
    check("t5_ptr_zero_grant", 32'(b_req_ready), 32'h1);
    @(negedge clk);
    b_req_valid = 2'b00;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("t5_no_stale_rsp", 32'(b_rsp_valid), 32'h0);
      @(negedge clk);
    end
    #1;
    check("t5_new_rsp_valid", 32'(b_rsp_valid), 32'h1);
    check("t5_new_rsp_data", 32'(b_rsp_data), 32'hFB);
    @(negedge clk); #1;
    check("t5_rsp_off", 32'(b_rsp_valid), 32'h0);
    check("t5_busy_off", 32'(b_busy), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
